spike_event_packer: RTL and testbench

SPIKE_EVENT_PACKER -- requirements
Module: spike_event_packer

---
 rtl/spike_event_packer.sv | 199 +++++++++++++++++++
 tb/tb_spike_event_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_packer.sv
// rtl/spike_event_packer.sv - captures spike events from a time-multiplexed neuron pool into a tagged FIFO with sweep/window counts
//
// Ports:
//   rawclk          clock, rising edge
//   reset_sim       synchronous active-low reset
//   enable          run request (low forces IDLE)
//   clear           synchronous clear of FIFO, counters and flags
//   neuronCounter   pool counter: [1:0] phase, [NN+2:2] neuron index
//   spike_in        spike flag of current neuron, valid in phase 3
//   window_sweeps   sweeps per accumulation window (0 treated as 1)
//   sweep_count     spike total of last completed sweep
//   sweep_done      one-cycle pulse when sweep_count updates
//   window_count    spike total of last completed window
//   window_valid    one-cycle pulse when window_count updates
//   rd_data         FIFO head {sweep_tag, index}, zero when empty
//   rd_valid        FIFO not empty (first-word-fall-through)
//   rd_en           pop request
//   overflow        sticky: an event was dropped on a full FIFO
//   drop_count      saturating count of dropped events
module spike_event_packer #(
    parameter int NN      = 8,
    parameter int FIFO_AW = 4
) (
    input  logic          rawclk,
    input  logic          reset_sim,
    input  logic          enable,
    input  logic          clear,
    input  logic [NN+2:0] neuronCounter,
    input  logic          spike_in,
    input  logic [15:0]   window_sweeps,
    output logic [NN+1:0] sweep_count,
    output logic          sweep_done,
    output logic [31:0]   window_count,
    output logic          window_valid,
    output logic [15:0]   rd_data,
    output logic          rd_valid,
    input  logic          rd_en,
    output logic          overflow,
    output logic [15:0]   drop_count
);
    localparam int TW    = 15 - NN;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]         state;
    logic [NN+2:0]      nc_prev;
    logic [NN+1:0]      sweep_acc;
    logic [TW-1:0]      sweep_tag;
    logic [15:0]        win_cnt;
    logic [15:0]        win_target;
    logic               win_open;
    logic [31:0]        win_sum;
    logic [31:0]        win_hold;
    logic               win_pend;
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;

    logic [NN:0]        idx;
    logic               strobe;
    logic               capture;
    logic               last_idx;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [NN+1:0]      acc_next;
    logic [15:0]        target_eff;
    logic [32:0]        win_add;
    logic [31:0]        win_total;

    always_comb begin
        idx        = neuronCounter[NN+2:2];
        // A strobe needs phase 3 and a counter value that actually changed,
        // so a stalled counter never re-samples the same neuron.
        strobe     = (neuronCounter[1:0] == 2'b11) && (neuronCounter != nc_prev);
        // ARM only synchronises on index 0; that strobe is itself captured.
        capture    = enable && strobe &&
                     ((state == S_RUN) || ((state == S_ARM) && (idx == '0)));
        last_idx   = (idx == '1);
        push       = capture && spike_in;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        pop        = rd_en && !fifo_empty;
        acc_next   = sweep_acc;
        if (push && (sweep_acc != '1)) begin
            acc_next = sweep_acc + (NN+2)'(1);
        end
        // The target is frozen at the first capture of a window.
        target_eff = win_open ? win_target :
                     ((window_sweeps == 16'd0) ? 16'd1 : window_sweeps);
        win_add    = {1'b0, win_sum} + 33'(acc_next);
        win_total  = win_add[32] ? 32'hFFFF_FFFF : win_add[31:0];
        rd_valid   = !fifo_empty;
        rd_data    = fifo_empty ? 16'h0000 : mem[rd_ptr[FIFO_AW-1:0]];
    end

    always_ff @(posedge rawclk) begin
        if (!reset_sim) begin
            state        <= S_IDLE;
            nc_prev      <= '0;
            sweep_acc    <= '0;
            sweep_tag    <= '0;
            win_cnt      <= '0;
            win_target   <= '0;
            win_open     <= 1'b0;
            win_sum      <= '0;
            win_hold     <= '0;
            win_pend     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sweep_count  <= '0;
            sweep_done   <= 1'b0;
            window_count <= '0;
            window_valid <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else begin
            nc_prev      <= neuronCounter;
            sweep_done   <= 1'b0;
            // Window result trails sweep_done by one cycle via win_pend.
            window_valid <= win_pend;
            win_pend     <= 1'b0;
            if (win_pend) begin
                window_count <= win_hold;
            end

            if (!enable) begin
                state <= S_IDLE;
            end else if (state == S_IDLE) begin
                state <= S_ARM;
            end else if (capture) begin
                state <= S_RUN;
            end

            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
                sweep_acc  <= '0;
                sweep_tag  <= '0;
                win_sum    <= '0;
                win_cnt    <= '0;
                win_open   <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
                end
                // A simultaneous pop frees the slot, so a full FIFO still accepts.
                if (push) begin
                    if (!fifo_full || pop) begin
                        mem[wr_ptr[FIFO_AW-1:0]] <= {sweep_tag, idx};
                        wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
                    end else begin
                        overflow <= 1'b1;
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end

                if (!enable) begin
                    sweep_acc <= '0;
                    win_sum   <= '0;
                    win_cnt   <= '0;
                    win_open  <= 1'b0;
                end else if (capture) begin
                    if (!win_open) begin
                        win_open   <= 1'b1;
                        win_target <= target_eff;
                    end
                    if (last_idx) begin
                        sweep_count <= acc_next;
                        sweep_done  <= 1'b1;
                        sweep_acc   <= '0;
                        sweep_tag   <= sweep_tag + TW'(1);
                        if ((win_cnt + 16'd1) == target_eff) begin
                            win_hold <= win_total;
                            win_pend <= 1'b1;
                            win_sum  <= '0;
                            win_cnt  <= '0;
                            win_open <= 1'b0;
                        end else begin
                            win_sum <= win_total;
                            win_cnt <= win_cnt + 16'd1;
                        end
                    end else begin
                        sweep_acc <= acc_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_event_packer.sv
// tb/tb_spike_event_packer.sv - randomized self-checking bench for spike_event_packer against a queue-based model
module tb_spike_event_packer;
    localparam int NN      = 2;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;

    logic        rawclk = 1'b0;
    logic        reset_sim = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  nc = '0;
    logic        spike_in = 1'b0;
    logic [15:0] window_sweeps = 16'd1;
    logic        rd_en = 1'b0;
    logic [3:0]  sweep_count;
    logic        sweep_done;
    logic [31:0] window_count;
    logic        window_valid;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        overflow;
    logic [15:0] drop_count;

    spike_event_packer #(.NN(NN), .FIFO_AW(FIFO_AW)) dut (
        .rawclk(rawclk), .reset_sim(reset_sim), .enable(enable), .clear(clear),
        .neuronCounter(nc), .spike_in(spike_in), .window_sweeps(window_sweeps),
        .sweep_count(sweep_count), .sweep_done(sweep_done),
        .window_count(window_count), .window_valid(window_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 rawclk = ~rawclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: 0 idle, 1 armed, 2 running
    int     m_state = 0;
    int     m_prev = 0;
    int     q[$];
    bit     m_ov = 0;
    int     m_drops = 0;
    int     m_acc = 0;
    int     m_tag = 0;
    int     m_wins = 0;
    int     m_wtarget = 1;
    bit     m_wopen = 0;
    longint m_wsum = 0;
    bit     m_pend = 0;
    longint m_pendval = 0;
    int     e_sc = 0;
    bit     e_sd = 0;
    longint e_wc = 0;
    bit     e_wv = 0;
    int     push_cnt = 0;
    int     pop_cnt = 0;

    always @(posedge rawclk) begin
        int idx;
        bit strobe, cap, push, pop;
        if (!reset_sim) begin
            m_state = 0; m_prev = 0; q.delete(); m_ov = 0; m_drops = 0; m_acc = 0;
            m_tag = 0; m_wins = 0; m_wopen = 0; m_wsum = 0; m_pend = 0;
            e_sc = 0; e_sd = 0; e_wc = 0; e_wv = 0;
        end else begin
            idx    = int'(nc) / 4;
            strobe = (int'(nc) % 4 == 3) && (int'(nc) != m_prev);
            m_prev = int'(nc);
            e_sd   = 0;
            e_wv   = m_pend;
            if (m_pend) e_wc = m_pendval;
            m_pend = 0;
            cap  = enable && strobe && (m_state == 2 || (m_state == 1 && idx == 0));
            pop  = rd_en && q.size() > 0;
            push = cap && spike_in;
            if (clear) begin
                q.delete(); m_ov = 0; m_drops = 0; m_acc = 0; m_wsum = 0;
                m_tag = 0; m_wins = 0; m_wopen = 0;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    pop_cnt++;
                end
                if (push) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(m_tag * 8 + idx);
                        push_cnt++;
                    end else begin
                        m_ov = 1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
                if (!enable) begin
                    m_acc = 0; m_wins = 0; m_wsum = 0; m_wopen = 0;
                end else if (cap) begin
                    if (push && m_acc < 15) m_acc++;
                    if (!m_wopen) begin
                        m_wopen = 1;
                        m_wtarget = (window_sweeps == 0) ? 1 : int'(window_sweeps);
                    end
                    if (idx == 7) begin
                        e_sc = m_acc;
                        e_sd = 1;
                        m_wsum = m_wsum + m_acc;
                        if (m_wsum > 64'hFFFF_FFFF) m_wsum = 64'hFFFF_FFFF;
                        m_acc = 0;
                        m_tag = (m_tag + 1) % 8192;
                        m_wins++;
                        if (m_wins == m_wtarget) begin
                            m_pend = 1; m_pendval = m_wsum;
                            m_wsum = 0; m_wins = 0; m_wopen = 0;
                        end
                    end
                end
            end
            if (!enable) m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (cap) m_state = 2;
        end
    end

    int cyc = 0;
    int sd_cnt = 0, wv_cnt = 0, sd_cyc = 0, wv_cyc = 0;
    int last_sc = 0;
    longint last_wc = 0;

    always @(posedge rawclk) begin
        #1;
        cyc++;
        chk("sweep_count", sweep_count, e_sc);
        chk("sweep_done", sweep_done, e_sd);
        chk("window_count", window_count, e_wc);
        chk("window_valid", window_valid, e_wv);
        chk("rd_valid", rd_valid, q.size() > 0);
        chk("rd_data", rd_data, (q.size() > 0) ? q[0] : 0);
        chk("overflow", overflow, m_ov);
        chk("drop_count", drop_count, m_drops);
        if (sweep_done) begin
            sd_cnt++; last_sc = sweep_count; sd_cyc = cyc;
        end
        if (window_valid) begin
            wv_cnt++; last_wc = window_count; wv_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge rawclk);
    endtask

    task automatic put(input int v, input bit s, input int hold);
        nc = 5'(v);
        spike_in = s;
        tick(hold);
    endtask

    task automatic sweep(input bit [7:0] pat, input int hold, input int first, input int last, input bit junk);
        for (int i = first; i <= last; i++)
            for (int p = 0; p < 4; p++)
                put(i * 4 + p, (p == 3 || !junk) ? pat[i] : 1'($urandom_range(0, 1)), hold);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sweep_count"}, sweep_count, 0);
        chk({tag, "_sweep_done"}, sweep_done, 0);
        chk({tag, "_window_count"}, window_count, 0);
        chk({tag, "_window_valid"}, window_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    initial begin
        int base_sd, base_wv, base_push, base_pop, v, a, b;
        bit [7:0] pat;

        tick(3);
        check_all_zero("reset");
        reset_sim = 1'b1;
        tick(1);

        // one sweep with spikes at 1, 5, 7
        window_sweeps = 16'd1;
        enable = 1'b1;
        tick(2);
        base_sd = sd_cnt;
        sweep(8'b1010_0010, 1, 0, 7, 1'b1);
        tick(3);
        chk("s036_sweep_done_pulses", sd_cnt - base_sd, 1);
        chk("s036_sweep_count", last_sc, 3);
        chk("s036_window_count", last_wc, 3);
        for (int k = 0; k < 3; k++) begin
            chk("s036_rd_valid", rd_valid, 1);
            chk("s036_word", rd_data, (k == 0) ? 16'h0001 : (k == 1) ? 16'h0005 : 16'h0007);
            rd_en = 1'b1; tick(1); rd_en = 1'b0;
        end
        chk("s036_empty", rd_valid, 0);

        // held counter values, spike constantly high
        pulse_clear();
        rd_en = 1'b1;
        base_sd = sd_cnt; base_push = push_cnt; base_pop = pop_cnt;
        sweep(8'hFF, 20, 0, 7, 1'b0);
        tick(3);
        rd_en = 1'b0;
        chk("s037_sweep_done_pulses", sd_cnt - base_sd, 1);
        chk("s037_sweep_count", last_sc, 8);
        chk("s037_pushes", push_cnt - base_push, 8);
        chk("s037_pops", pop_cnt - base_pop, 8);
        chk("s037_drop_count", drop_count, 0);

        // three-sweep window, two spikes per sweep
        pulse_clear();
        window_sweeps = 16'd3;
        rd_en = 1'b1;
        base_wv = wv_cnt;
        for (int s = 0; s < 3; s++) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            pat = '0; pat[a] = 1'b1; pat[b] = 1'b1;
            sweep(pat, 1, 0, 7, 1'b1);
        end
        tick(4);
        rd_en = 1'b0;
        chk("s038_window_pulses", wv_cnt - base_wv, 1);
        chk("s038_window_count", last_wc, 6);
        chk("s038_window_latency", wv_cyc - sd_cyc, 1);

        // overflow with a 4-word FIFO
        pulse_clear();
        window_sweeps = 16'd1;
        sweep(8'b0111_1110, 1, 0, 7, 1'b1);
        tick(2);
        chk("s039_overflow", overflow, 1);
        chk("s039_drop_count", drop_count, 2);
        for (int k = 0; k < 4; k++) begin
            chk("s039_word", rd_data, k + 1);
            rd_en = 1'b1; tick(1); rd_en = 1'b0;
        end
        chk("s039_empty", rd_valid, 0);

        // enable raised mid-sweep, then dropped mid-sweep
        pulse_clear();
        enable = 1'b0;
        tick(2);
        put(12, 1'b0, 1);
        enable = 1'b1;
        base_sd = sd_cnt;
        sweep(8'hFF, 1, 3, 7, 1'b1);
        chk("s040_no_capture_before_0", rd_valid, 0);
        sweep(8'hFF, 1, 0, 3, 1'b1);
        enable = 1'b0;
        sweep(8'hFF, 1, 4, 7, 1'b1);
        tick(3);
        chk("s040_no_sweep_done", sd_cnt - base_sd, 0);
        chk("s040_overflow", overflow, 0);
        for (int k = 0; k < 4; k++) begin
            chk("s040_word", rd_data, k);
            rd_en = 1'b1; tick(1); rd_en = 1'b0;
        end

        // randomized traffic
        enable = 1'b1;
        v = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 5) v = $urandom_range(0, 31);
            else v = (v + 1) % 32;
            rd_en = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 99) == 0) window_sweeps = 16'($urandom_range(0, 3));
            put(v, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
        clear = 1'b0; rd_en = 1'b0;

        // reset while running with three words queued
        pulse_clear();
        enable = 1'b0; tick(1);
        enable = 1'b1; tick(1);
        sweep(8'b0000_0111, 1, 0, 3, 1'b1);
        chk("s041_pre_rd_valid", rd_valid, 1);
        reset_sim = 1'b0;
        tick(1);
        check_all_zero("s041");
        reset_sim = 1'b1;
        base_sd = sd_cnt;
        sweep(8'hFF, 1, 4, 7, 1'b1);
        tick(2);
        chk("s041_idle_no_capture", rd_valid, 0);
        chk("s041_idle_no_sweep", sd_cnt - base_sd, 0);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
